// File: rtl/riscv_wb_unit.sv
// riscv_wb_unit: registered write-back stage with variable-latency load return,
// lane extraction, and misalignment/timeout reporting.
module riscv_wb_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int PC_WIDTH    = 15,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_WIDTH    = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [PC_WIDTH-1:0]   in_pc_4,
    input  logic [1:0]            in_wbsel,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  misalign_err,
    output logic                  timeout_err
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                r_state, w_state_n;
    logic [TO_WIDTH-1:0]   r_cnt, w_cnt_n;
    logic                  r_we, w_we_n, r_mis, w_mis_n, r_to, w_to_n;
    logic [4:0]            r_waddr, w_waddr_n, r_rd;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n, w_load_data;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic                  w_acc, w_is_load, w_misaligned, w_unused;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign in_ready     = (r_state == IDLE);
    assign w_acc        = in_valid & in_ready;
    assign w_is_load    = (in_wbsel == 2'b00) && (in_inst[6:0] == 7'b0000011);
    assign w_byte       = mem_rdata[8*r_off +: 8];
    assign w_half       = mem_rdata[16*r_off[1] +: 16];
    // funct3[1:0]: 00 byte, 01 half, 1x word (every other encoding is a full word)
    assign w_load_data  = (r_f3 == 3'b000) ? {{(DATA_WIDTH-8){w_byte[7]}}, w_byte} :
                          (r_f3 == 3'b100) ? {{(DATA_WIDTH-8){1'b0}}, w_byte} :
                          (r_f3 == 3'b001) ? {{(DATA_WIDTH-16){w_half[15]}}, w_half} :
                          (r_f3 == 3'b101) ? {{(DATA_WIDTH-16){1'b0}}, w_half} : mem_rdata;
    assign w_misaligned = (r_f3[1:0] == 2'b01) ? r_off[0] : r_f3[1] && (r_off != 2'b00);
    assign w_unused     = &{1'b0, in_inst[DATA_WIDTH-1:15]};

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_we_n    = 1'b0;
        w_mis_n   = 1'b0;
        w_to_n    = 1'b0;
        w_waddr_n = r_waddr;
        w_wdata_n = r_wdata;
        if (r_state == IDLE) begin
            if (w_acc && w_is_load) begin
                w_state_n = WAIT;
                w_cnt_n   = '0;
            end else if (w_acc && (in_wbsel == 2'b01 || in_wbsel == 2'b10) && in_inst[11:7] != 5'd0) begin
                w_we_n    = 1'b1;
                w_waddr_n = in_inst[11:7];
                w_wdata_n = in_wbsel[0] ? in_alu : {{(DATA_WIDTH-PC_WIDTH){1'b0}}, in_pc_4};
            end
        end else if (mem_rvalid) begin
            w_state_n = IDLE;
            w_mis_n   = w_misaligned;
            if (!w_misaligned && r_rd != 5'd0) begin
                w_we_n    = 1'b1;
                w_waddr_n = r_rd;
                w_wdata_n = w_load_data;
            end
        end else if (r_cnt == TO_WIDTH'(MEM_TIMEOUT - 1)) begin
            w_state_n = IDLE;
            w_to_n    = 1'b1;
        end else begin
            w_cnt_n = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_we    <= w_we_n;
            r_mis   <= w_mis_n;
            r_to    <= w_to_n;
            r_waddr <= w_waddr_n;
            r_wdata <= w_wdata_n;
            if (w_acc && w_is_load) begin
                r_rd  <= in_inst[11:7];
                r_f3  <= in_inst[14:12];
                r_off <= in_alu[1:0];
            end
        end
    end

    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign misalign_err = r_mis;
    assign timeout_err  = r_to;
endmodule

// File: doc/riscv_wb_unit.md
Name: riscv_wb_unit

Overview:
- Registered, handshaked write-back stage for the RISC-V pipeline.
- Selects the register-file write data from the ALU result, PC+4, or load data, and performs byte/halfword lane extraction with sign or zero extension.
- Load data may return from data memory with variable latency; the block stalls upstream while it waits.
- Flags misaligned loads and memory timeouts instead of writing the register file.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is legal (RV32).
- PC_WIDTH, 15, width of in_pc_4; zero-extended to DATA_WIDTH.
- MEM_TIMEOUT, 16, maximum cycles spent in WAIT before abandoning a load (must be ≥1).
- TO_WIDTH, $clog2(MEM_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  write-back-bound instruction presented.
- in_ready  out  1  block can accept; transfer occurs when in_valid & in_ready.
- in_inst  in  DATA_WIDTH  instruction; uses [6:0] opcode, [11:7] rd, [14:12] funct3.
- in_alu  in  DATA_WIDTH  ALU result; for loads this is the effective address.
- in_pc_4  in  PC_WIDTH  PC+4.
- in_wbsel  in  2  00 = memory, 01 = ALU, 10 = PC+4, 11 = no write.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_WIDTH  aligned 32-bit memory word.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  5  destination register.
- rf_wdata  out  DATA_WIDTH  write data.
- misalign_err  out  1  one-cycle pulse on a misaligned load.
- timeout_err  out  1  one-cycle pulse on a load timeout.

Behaviour:
- States: IDLE, WAIT.
- Reset: state IDLE, counter 0; rf_we, rf_waddr, rf_wdata, misalign_err, timeout_err all 0. rst overrides every other input in the same cycle, including mid-WAIT; a pending load is dropped.
- in_ready = 1 in IDLE and 0 in WAIT (combinational from state only).
- Load definition: in_wbsel == 00 and opcode == 7'b0000011.

IDLE, accepted non-load:
- Registered result appears the next cycle, so latency is 1.
- rf_we = 1 for that cycle if in_wbsel is 01 or 10 and rd != 0.
- wbsel 01 → in_alu; wbsel 10 → {zeros, in_pc_4}.
- wbsel 11, or wbsel 00 with a non-load opcode → rf_we = 0 and no error.
- Back-to-back acceptance at 1 per cycle.

IDLE, accepted load:
- Capture rd, funct3, and off = in_alu[1:0]; enter WAIT; clear counter.

WAIT:
- mem_rvalid is sampled only in WAIT, so the earliest response is the cycle after acceptance.
- Each cycle without mem_rvalid: counter += 1. When counter reaches MEM_TIMEOUT-1 without mem_rvalid → next cycle timeout_err = 1, rf_we = 0, return to IDLE.
- On mem_rvalid → return to IDLE; the next cycle produces the write or the error.

Lane extraction (from the captured funct3):
- byte = mem_rdata[8*off +: 8]
- half = mem_rdata[16*off[1] +: 16]
- 000 LB: sign-extend byte.
- 100 LBU: zero-extend byte.
- 001 LH: sign-extend half.
- 101 LHU: zero-extend half.
- 010 LW, and all other funct3: full word.

Misalignment:
- Half loads with off[0] = 1, or word loads with off != 0, are misaligned.
- On the response: misalign_err = 1, rf_we = 0; the data is discarded.
- Loads with rd = 0 still wait and still check alignment; rf_we stays 0.

Outputs:
- rf_we, misalign_err and timeout_err are never high together.
- rf_waddr and rf_wdata hold their last values when rf_we = 0.
- A mem_rvalid arriving in IDLE (stale or late) is ignored.

Test Plan:
1. Reset, then ALU op rd = 5, in_alu = 0x1234_5678, wbsel 01 → next cycle rf_we = 1, waddr = 5, wdata = 0x1234_5678. Follow with JAL rd = 1, pc_4 = 0x0104, wbsel 10, issued back-to-back → wdata = 0x0000_0104 one cycle later; in_ready stays 1 throughout.
2. LB rd = 3, addr = 0x...2; after 3 cycles mem_rdata = 0x11F2_3344 with mem_rvalid → in_ready = 0 for 4 cycles; rf_we pulse with wdata = 0xFFFF_FFF2. Repeat as LBU → 0x0000_00F2.
3. LH at off = 2, mem_rdata = 0x8001_0000 → 0xFFFF_8001. LHU at off = 2 → 0x0000_8001. LH at off = 1 → misalign_err pulse, rf_we = 0.
4. LW with no mem_rvalid for MEM_TIMEOUT cycles → timeout_err pulses, state IDLE, in_ready = 1. A mem_rvalid pulse afterwards produces no write.
5. rst asserted on the second cycle of WAIT, with mem_rvalid high in that same cycle → no write, all outputs 0, in_ready = 1 the next cycle.
6. wbsel 11, ALU op with rd = 0, and a store (wbsel 00, opcode 0100011) → rf_we stays 0, no errors, no stall.
